// File: rtl/eth_rx_parser_pkg.sv
// Shared definitions for the Ethernet receive parser: FSM states,
// framing constants and header field lengths.
// Optional feature macro: ETH_RX_FCS_STRIP_EN (strip the trailing 4 FCS bytes
// from the payload stream).
package eth_rx_pkg;

    // Parser states, in frame order.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRE     = 3'd1,
        DST     = 3'd2,
        SRC     = 3'd3,
        TYPE    = 3'd4,
        PAYLOAD = 3'd5
    } state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
    localparam logic [7:0] SFD_BYTE      = 8'hBA;

    // Header field lengths in bytes, sized for the 4-bit field byte counter.
    localparam logic [3:0] DST_LEN  = 4'd6;
    localparam logic [3:0] SRC_LEN  = 4'd6;
    localparam logic [3:0] TYPE_LEN = 4'd2;

    // Trailing frame check sequence length in bytes.
    localparam int FCS_LEN = 4;

    // Width of the payload length counter.
    localparam int PL_LEN_W = 11;

`ifdef ETH_RX_FCS_STRIP_EN
    localparam bit FCS_STRIP = 1'b1;
`else
    localparam bit FCS_STRIP = 1'b0;
`endif

    // Shift one byte into the LSB end of a 48-bit MAC field.
    function automatic logic [47:0] shift_mac(input logic [47:0] field,
                                              input logic [7:0]  b);
        return {field[39:0], b};
    endfunction

endpackage

// File: rtl/eth_rx_parser_if.sv
// Byte input and parsed-frame output bundle of the Ethernet receive parser.
// master: upstream byte source / downstream consumer; slave: the parser.
interface eth_rx_parser_if;
    import eth_rx_pkg::*;

    // Byte stream from the MII nibble assembler.
    logic                rdy;
    logic [7:0]          q;
    logic                mii_en;

    // Parsed header, payload stream and frame status.
    logic [47:0]         dst;
    logic [47:0]         src;
    logic [15:0]         etype;
    logic                hdr_vld;
    logic [7:0]          pl_d;
    logic                pl_vld;
    logic [PL_LEN_W-1:0] pl_len;
    logic                frame_done;
    logic                frame_err;
    logic [31:0]         fcs;

    modport master (
        output rdy, q, mii_en,
        input  dst, src, etype, hdr_vld, pl_d, pl_vld, pl_len,
               frame_done, frame_err, fcs
    );

    modport slave (
        input  rdy, q, mii_en,
        output dst, src, etype, hdr_vld, pl_d, pl_vld, pl_len,
               frame_done, frame_err, fcs
    );

endinterface

// File: rtl/eth_rx_fcs_buf.sv
// Four-byte window over the most recent bytes received after the SFD.
// The oldest byte sits in tap_o[31:24]; it doubles as the FCS capture
// register and as the delay line used when FCS stripping is enabled
// (macro ETH_RX_FCS_STRIP_EN, selected in the parser).
module eth_rx_fcs_buf (
    input  logic        mii_clk,
    input  logic        reset,
    input  logic        shift_i,
    input  logic        flush_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] tap_o
);

    logic [31:0] tap_q;

    // Flush at the start of a frame, otherwise shift in each accepted byte.
    always_ff @(posedge mii_clk or posedge reset) begin
        if (reset) begin
            tap_q <= '0;
        end else if (flush_i) begin
            tap_q <= '0;
        end else if (shift_i) begin
            tap_q <= {tap_q[23:0], byte_i};
        end
    end

    assign tap_o = tap_q;

endmodule

// File: rtl/eth_rx_parser.sv
// Ethernet receive parser: turns the upstream byte stream into header
// fields, a payload byte stream and per-frame done/error pulses.
// Optional macro ETH_RX_FCS_STRIP_EN: payload passes through a 4-byte delay
// line so the trailing FCS bytes are never emitted nor counted in pl_len.
module eth_rx_parser
    import eth_rx_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic          mii_clk,
    input  logic          reset,
    eth_rx_parser_if.slave bus
);

    // Raw payload bytes allowed per frame; with stripping the FCS bytes do
    // not count towards MAX_PAYLOAD, so the raw budget grows by FCS_LEN.
    localparam logic [PL_LEN_W-1:0] RAW_LIMIT =
        PL_LEN_W'(MAX_PAYLOAD + (FCS_STRIP ? FCS_LEN : 0));

    logic                rdy_q;
    logic                strobe;

    state_e              state_q,   state_d;
    logic [3:0]          cnt_q,     cnt_d;
    logic [47:0]         dst_q,     dst_d;
    logic [47:0]         src_q,     src_d;
    logic [15:0]         etype_q,   etype_d;
    logic                hdr_vld_q, hdr_vld_d;
    logic [7:0]          pl_d_q,    pl_d_d;
    logic                pl_vld_q,  pl_vld_d;
    logic [PL_LEN_W-1:0] pl_len_q,  pl_len_d;
    logic [PL_LEN_W-1:0] raw_cnt_q, raw_cnt_d;
    logic                done_q,    done_d;
    logic                err_q,     err_d;
    logic [31:0]         fcs_q,     fcs_d;

    logic                buf_shift;
    logic                buf_flush;
    logic [31:0]         tap;

    // Register rdy once so a level held high still yields a single byte.
    always_ff @(posedge mii_clk or posedge reset) begin
        if (reset) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= bus.rdy;
        end
    end

    assign strobe = bus.rdy & ~rdy_q;

    // Window of the last four bytes after the SFD.
    eth_rx_fcs_buf u_fcs_buf (
        .mii_clk (mii_clk),
        .reset   (reset),
        .shift_i (buf_shift),
        .flush_i (buf_flush),
        .byte_i  (bus.q),
        .tap_o   (tap)
    );

    // FSM state register.
    always_ff @(posedge mii_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath: the byte on this strobe is applied first,
    // then a low mii_en closes the frame based on where that byte left us.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dst_d     = dst_q;
        src_d     = src_q;
        etype_d   = etype_q;
        pl_d_d    = pl_d_q;
        pl_len_d  = pl_len_q;
        raw_cnt_d = raw_cnt_q;
        fcs_d     = fcs_q;
        hdr_vld_d = 1'b0;
        pl_vld_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        buf_shift = 1'b0;
        buf_flush = 1'b0;

        if (strobe) begin
            case (state_q)
                IDLE: begin
                    if (bus.mii_en && (bus.q == PREAMBLE_BYTE)) begin
                        state_d = PRE;
                    end
                end
                PRE: begin
                    if (bus.q == SFD_BYTE) begin
                        state_d   = DST;
                        cnt_d     = '0;
                        dst_d     = '0;
                        src_d     = '0;
                        etype_d   = '0;
                        pl_len_d  = '0;
                        raw_cnt_d = '0;
                        fcs_d     = '0;
                        buf_flush = 1'b1;
                    end else if (bus.q != PREAMBLE_BYTE) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                DST: begin
                    dst_d     = shift_mac(dst_q, bus.q);
                    buf_shift = 1'b1;
                    if (cnt_q == DST_LEN - 4'd1) begin
                        cnt_d   = '0;
                        state_d = SRC;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                SRC: begin
                    src_d     = shift_mac(src_q, bus.q);
                    buf_shift = 1'b1;
                    if (cnt_q == SRC_LEN - 4'd1) begin
                        cnt_d   = '0;
                        state_d = TYPE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                TYPE: begin
                    etype_d   = {etype_q[7:0], bus.q};
                    buf_shift = 1'b1;
                    if (cnt_q == TYPE_LEN - 4'd1) begin
                        cnt_d     = '0;
                        hdr_vld_d = 1'b1;
                        state_d   = PAYLOAD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                PAYLOAD: begin
                    if (raw_cnt_q == RAW_LIMIT) begin
                        // Oversized frame: drop this byte and abort.
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        raw_cnt_d = raw_cnt_q + 1'b1;
                        buf_shift = 1'b1;
`ifdef ETH_RX_FCS_STRIP_EN
                        // Emit the byte leaving the 4-byte delay line once
                        // it holds only payload bytes.
                        if (raw_cnt_q >= PL_LEN_W'(FCS_LEN)) begin
                            pl_vld_d = 1'b1;
                            pl_d_d   = tap[31:24];
                            pl_len_d = pl_len_q + 1'b1;
                        end
`else
                        pl_vld_d = 1'b1;
                        pl_d_d   = bus.q;
                        pl_len_d = pl_len_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (!bus.mii_en) begin
            case (state_d)
                PRE: begin
                    state_d = IDLE;
                end
                DST, SRC, TYPE: begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
                PAYLOAD: begin
                    // Capture the window including any byte taken this cycle.
                    done_d  = 1'b1;
                    fcs_d   = buf_shift ? {tap[23:0], bus.q} : tap;
                    state_d = IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge mii_clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            dst_q     <= '0;
            src_q     <= '0;
            etype_q   <= '0;
            hdr_vld_q <= 1'b0;
            pl_d_q    <= '0;
            pl_vld_q  <= 1'b0;
            pl_len_q  <= '0;
            raw_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fcs_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            etype_q   <= etype_d;
            hdr_vld_q <= hdr_vld_d;
            pl_d_q    <= pl_d_d;
            pl_vld_q  <= pl_vld_d;
            pl_len_q  <= pl_len_d;
            raw_cnt_q <= raw_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            fcs_q     <= fcs_d;
        end
    end

    assign bus.dst        = dst_q;
    assign bus.src        = src_q;
    assign bus.etype      = etype_q;
    assign bus.hdr_vld    = hdr_vld_q;
    assign bus.pl_d       = pl_d_q;
    assign bus.pl_vld     = pl_vld_q;
    assign bus.pl_len     = pl_len_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.fcs        = fcs_q;

endmodule

// File: tb/tb_eth_rx_parser.sv
// Scoreboard bench for eth_rx_parser: drivers push expected events into
// per-DUT queues, monitors pop and compare on every output pulse.
// Two instances: default MAX_PAYLOAD and MAX_PAYLOAD=8.
module tb_eth_rx_parser;

`ifdef ETH_RX_FCS_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    localparam int K_PL   = 0;
    localparam int K_HDR  = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int          kind;
        logic [47:0] a;
        logic [47:0] b;
        logic [31:0] c;
    } evt_t;

    logic mii_clk = 1'b0;
    logic reset;

    always #5 mii_clk = ~mii_clk;

    eth_rx_parser_if bus_a ();
    eth_rx_parser_if bus_b ();

    eth_rx_parser u_dut (
        .mii_clk (mii_clk),
        .reset   (reset),
        .bus     (bus_a)
    );

    eth_rx_parser #(.MAX_PAYLOAD(8)) u_dut8 (
        .mii_clk (mii_clk),
        .reset   (reset),
        .bus     (bus_b)
    );

    evt_t        exp_a[$];
    evt_t        exp_b[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  pl_buf [64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int sel, input int kind, input logic [47:0] a,
                        input logic [47:0] b, input logic [31:0] c);
        evt_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c;
        if (sel == 0) exp_a.push_back(e);
        else          exp_b.push_back(e);
    endtask

    task automatic take(input int sel, input int kind, input logic [47:0] a,
                        input logic [47:0] b, input logic [31:0] c);
        evt_t  e;
        bit    empty;
        string tag;
        tag   = (sel == 0) ? "dut" : "dut8";
        empty = 1'b0;
        if (sel == 0) begin
            if (exp_a.size() == 0) empty = 1'b1; else e = exp_a.pop_front();
        end else begin
            if (exp_b.size() == 0) empty = 1'b1; else e = exp_b.pop_front();
        end
        $display("[%0t] %s event kind=%0d a=%h b=%h c=%h", $time, tag, kind, a, b, c);
        if (empty) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s unexpected event: got kind %0d expected none", tag, kind);
            return;
        end
        chk({tag, " kind"}, 64'(kind), 64'(e.kind));
        case (e.kind)
            K_PL: begin
                chk({tag, " pl_d"}, {16'b0, a}, {16'b0, e.a});
                chk({tag, " pl_len"}, {16'b0, b}, {16'b0, e.b});
            end
            K_HDR: begin
                chk({tag, " dst"}, {16'b0, a}, {16'b0, e.a});
                chk({tag, " src"}, {16'b0, b}, {16'b0, e.b});
                chk({tag, " etype"}, {32'b0, c}, {32'b0, e.c});
            end
            K_DONE: begin
                chk({tag, " done pl_len"}, {16'b0, b}, {16'b0, e.b});
                chk({tag, " fcs"}, {32'b0, c}, {32'b0, e.c});
            end
            default: begin
            end
        endcase
    endtask

    // Monitors: sample away from the active edge and pop on each pulse.
    always @(negedge mii_clk) begin
        if (!reset) begin
            if (bus_a.pl_vld)     take(0, K_PL, {40'b0, bus_a.pl_d}, {37'b0, bus_a.pl_len}, 32'h0);
            if (bus_a.hdr_vld)    take(0, K_HDR, bus_a.dst, bus_a.src, {16'b0, bus_a.etype});
            if (bus_a.frame_done) take(0, K_DONE, 48'h0, {37'b0, bus_a.pl_len}, bus_a.fcs);
            if (bus_a.frame_err)  take(0, K_ERR, 48'h0, 48'h0, 32'h0);
            if (bus_b.pl_vld)     take(1, K_PL, {40'b0, bus_b.pl_d}, {37'b0, bus_b.pl_len}, 32'h0);
            if (bus_b.hdr_vld)    take(1, K_HDR, bus_b.dst, bus_b.src, {16'b0, bus_b.etype});
            if (bus_b.frame_done) take(1, K_DONE, 48'h0, {37'b0, bus_b.pl_len}, bus_b.fcs);
            if (bus_b.frame_err)  take(1, K_ERR, 48'h0, 48'h0, 32'h0);
        end
    end

    task automatic drive(input int sel, input logic r, input logic [7:0] d, input logic en);
        if (sel == 0) begin
            bus_a.rdy = r; bus_a.q = d; bus_a.mii_en = en;
        end else begin
            bus_b.rdy = r; bus_b.q = d; bus_b.mii_en = en;
        end
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input int hold);
        drive(sel, 1'b1, b, 1'b1);
        repeat (hold) @(posedge mii_clk);
        #1;
        drive(sel, 1'b0, b, 1'b1);
        @(posedge mii_clk);
        #1;
    endtask

    task automatic end_frame(input int sel);
        drive(sel, 1'b0, 8'h00, 1'b0);
        repeat (4) @(posedge mii_clk);
        #1;
    endtask

    // Sends preamble, SFD, header and the first nsend bytes of pl_buf,
    // pushing the expected events just ahead of the bytes that cause them.
    task automatic send_frame(input int sel, input int npre, input logic [47:0] d,
                              input logic [47:0] s, input logic [15:0] et,
                              input int npl, input int nsend, input bit do_end,
                              input int hold);
        int lim;
        bit ovf;
        lim = ((sel == 0) ? 1500 : 8) + (STRIP ? 4 : 0);
        ovf = 1'b0;
        drive(sel, 1'b0, 8'h00, 1'b1);
        @(posedge mii_clk);
        #1;
        repeat (npre) send_byte(sel, 8'hAA, hold);
        send_byte(sel, 8'hBA, hold);
        for (int i = 0; i < 6; i++) send_byte(sel, d[47-8*i -: 8], hold);
        for (int i = 0; i < 6; i++) send_byte(sel, s[47-8*i -: 8], hold);
        push(sel, K_HDR, d, s, {16'b0, et});
        send_byte(sel, et[15:8], hold);
        send_byte(sel, et[7:0], hold);
        for (int i = 0; i < nsend; i++) begin
            if (!ovf) begin
                if (i >= lim) begin
                    ovf = 1'b1;
                    push(sel, K_ERR, 48'h0, 48'h0, 32'h0);
                end else if (!STRIP) begin
                    push(sel, K_PL, {40'b0, pl_buf[i]}, 48'(i + 1), 32'h0);
                end else if (i >= 4) begin
                    push(sel, K_PL, {40'b0, pl_buf[i-4]}, 48'(i - 3), 32'h0);
                end
            end
            send_byte(sel, pl_buf[i], hold);
        end
        if (do_end) begin
            if (!ovf) begin
                push(sel, K_DONE, 48'h0, 48'(STRIP ? npl - 4 : npl),
                     {pl_buf[npl-4], pl_buf[npl-3], pl_buf[npl-2], pl_buf[npl-1]});
            end
            end_frame(sel);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " dst"},    {16'b0, bus_a.dst}, 64'h0);
        chk({tag, " src"},    {16'b0, bus_a.src}, 64'h0);
        chk({tag, " etype"},  {48'b0, bus_a.etype}, 64'h0);
        chk({tag, " pl_len"}, {53'b0, bus_a.pl_len}, 64'h0);
        chk({tag, " fcs"},    {32'b0, bus_a.fcs}, 64'h0);
        chk({tag, " pl_d"},   {56'b0, bus_a.pl_d}, 64'h0);
        chk({tag, " pulses"}, {60'b0, bus_a.hdr_vld, bus_a.pl_vld,
                               bus_a.frame_done, bus_a.frame_err}, 64'h0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge mii_clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge mii_clk);
        #1;
        chk_zero("post-reset");

        // Reference frame: 32 payload bytes followed by a 4-byte FCS.
        for (int i = 0; i < 32; i++) pl_buf[i] = 8'(i * 5 + 1);
        pl_buf[32] = 8'hDE; pl_buf[33] = 8'hAD; pl_buf[34] = 8'hBE; pl_buf[35] = 8'hEF;
        send_frame(0, 7, 48'h54ff01212324, 48'h123456789abc, 16'h1234, 36, 36, 1'b1, 1);

        // Bad preamble byte aborts, then a short good frame parses.
        drive(0, 1'b0, 8'h00, 1'b1);
        send_byte(0, 8'hAA, 1);
        send_byte(0, 8'hAA, 1);
        push(0, K_ERR, 48'h0, 48'h0, 32'h0);
        send_byte(0, 8'h55, 1);
        end_frame(0);
        for (int i = 0; i < 6; i++) pl_buf[i] = 8'(10 * (i + 1));
        send_frame(0, 2, 48'h0a0b0c0d0e0f, 48'hfedcba987654, 16'h0800, 6, 6, 1'b1, 1);

        // mii_en dropped after the third destination byte.
        drive(0, 1'b0, 8'h00, 1'b1);
        send_byte(0, 8'hAA, 1);
        send_byte(0, 8'hBA, 1);
        send_byte(0, 8'h01, 1);
        send_byte(0, 8'h02, 1);
        send_byte(0, 8'h03, 1);
        push(0, K_ERR, 48'h0, 48'h0, 32'h0);
        end_frame(0);

        // Oversized payload on the MAX_PAYLOAD=8 instance.
        for (int i = 0; i < 10; i++) pl_buf[i] = 8'(16 * i + 3);
        send_frame(1, 3, 48'h111111111111, 48'h222222222222, 16'h88b5, 10, 10, 1'b1, 1);

        // Reset in the middle of the payload.
        for (int i = 0; i < 20; i++) pl_buf[i] = 8'(i + 100);
        send_frame(0, 7, 48'h020406080a0c, 48'h030507090b0d, 16'h86dd, 20, 5, 1'b0, 1);
        reset = 1'b1;
        #1;
        chk_zero("mid-frame reset");
        chk("queue drained at reset", 64'(exp_a.size()), 64'h0);
        drive(0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge mii_clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge mii_clk);
        #1;
        for (int i = 0; i < 8; i++) pl_buf[i] = 8'(i * 9 + 7);
        send_frame(0, 7, 48'h665544332211, 48'h0123456789ab, 16'h0806, 8, 8, 1'b1, 1);

        // rdy held high for three cycles per byte.
        for (int i = 0; i < 12; i++) pl_buf[i] = 8'(200 - i * 3);
        send_frame(0, 7, 48'hc0ffee000001, 48'hbadc0ffee000, 16'h9000, 12, 12, 1'b1, 3);

        repeat (10) @(posedge mii_clk);
        #1;
        chk("dut queue drained", 64'(exp_a.size()), 64'h0);
        chk("dut8 queue drained", 64'(exp_b.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
